branch_flags_unit: RTL and testbench
====================================

Name: branch_flags_unit

Overview:
- Consumer end of the adder_sub compare interface. Latches the Gt/Eq outputs into the architectural flags register on cmp.
- Resolves b/beq/bgt/call/ret against those flags, owns the fetch PC and produces the return-address write for call.
- Drives a counted pipeline flush after every taken redirect. Sits in the execute stage next to adder_sub.

Parameters:
- PC_W, 32, PC and data width.
- OFF_W, 27, branch offset field width, in words.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FLUSH_CYCLES, 2, cycles of flush after a taken redirect (1..7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freezes all state when high.
- ex_valid  in  1  execute-stage instruction is valid.
- ex_pc  in  PC_W  PC of the execute-stage instruction.
- is_cmp  in  1  cmp instruction; writes flags.
- gt_in  in  1  Gt from adder_sub.
- eq_in  in  1  Eq from adder_sub.
- is_b, is_beq, is_bgt, is_call, is_ret  in  1 each  branch opcode decodes.
- offset  in  OFF_W  signed word offset.
- op1  in  PC_W  ra register value, used by ret.
- pc  out  PC_W  fetch PC.
- flag_gt, flag_eq  out  1 each  flags register.
- branch_taken  out  1  one-cycle redirect pulse.
- branch_pc  out  PC_W  redirect target, valid with branch_taken.
- ra_wr_en  out  1  write ra (r15).
- ra_wr_data  out  PC_W  return address.
- flush  out  1  squash younger instructions.

Behaviour:
- **Reset (reset=0, async):**
  - pc=RESET_PC.
  - flag_gt=flag_eq=0, branch_taken=0, branch_pc=0, ra_wr_en=0, ra_wr_data=0, flush=0.
  - FSM in RUN, flush counter=0.
  - Reset asserted mid-flush aborts the flush immediately.
- **Effective instruction:** eff = ex_valid & ~stall & (state==RUN). Wrong-path instructions seen during FLUSH are ignored entirely: no flag write, no redirect, no ra write.
- **Flags:**
  - On a clock edge with eff & is_cmp: flag_gt<=gt_in, flag_eq<=eq_in.
  - Otherwise the flags hold.
  - Branches always evaluate the registered flags; there is no forwarding from a cmp in the same cycle.
- **Taken condition:**
  - b, call, ret: unconditional.
  - beq: flag_eq.
  - bgt: flag_gt.
- **Priority** when several decodes are high (decoder error): ret > call > b > bgt > beq. is_cmp is independent of the branch decodes.
- **Target:**
  - ret: op1.
  - All others: ex_pc + (sign_extend(offset) << 2), computed mod 2^PC_W (wrap, no overflow flag).
- **Edge after a taken effective branch (cycle N):**
  - pc<=target.
  - branch_taken<=1, branch_pc<=target; both high for exactly cycle N+1.
  - FSM->FLUSH, counter<=FLUSH_CYCLES, flush=1 for cycles N+1..N+FLUSH_CYCLES.
- **Edge after a non-stalled cycle with no redirect:** pc<=pc+4 (wraps at 2^PC_W); branch_taken<=0.
- **call:** ra_wr_en<=1 and ra_wr_data<=ex_pc+4 on the same edge as the redirect; high for one cycle.
- **FSM:**
  - RUN -> FLUSH on a taken effective branch.
  - In FLUSH, the counter decrements each non-stalled cycle; flush = (counter != 0).
  - FLUSH -> RUN on the edge where the counter goes 1->0.
- **stall=1:**
  - pc, flags, FSM, counter, branch_pc and ra_wr_data hold.
  - branch_taken and ra_wr_en are forced to 0 on that edge; the pulses are never repeated.
  - flush holds its value.
- **Not-taken beq/bgt:** treated exactly as a non-branch (pc+4, no flush).

Decomposition:
- Shared package `simplerisc_pkg`:
  - Constants PC_W, OFF_W, RA_IDX=4'd15.
  - FSM enum {RUN, FLUSH}.
  - Branch-kind enum {BR_NONE, BR_B, BR_BEQ, BR_BGT, BR_CALL, BR_RET}.
- One natural sub-module: `branch_target_calc`, a combinational block covering sign-extend, shift, add and ret mux.
- The flags register, PC register and flush FSM stay in the top.

Test Plan:
1. Reset low for 10 time units, release -> pc=0, flags=0, flush=0; after 3 unstalled cycles pc=12.
2. cmp with gt_in=1, eq_in=0 (30 vs 10), then bgt at ex_pc=0x40, offset=3 -> next edge: branch_pc=0x4C, branch_taken pulse for 1 cycle, flush high exactly 2 cycles.
3. cmp with eq_in=1 (25 vs 25), then beq offset=-2 at ex_pc=0x100 -> target 0xF8. A bgt issued after a cmp of 10 vs 20 -> not taken, pc advances by 4, no flush.
4. call at ex_pc=0x200, offset=0x10 -> ra_wr_en pulse, ra_wr_data=0x204, pc=0x240. A later ret with op1=0x204 -> pc=0x204.
5. Taken b, then during FLUSH present cmp(gt_in=1) and is_b -> flags unchanged, no second redirect. stall=1 for 3 cycles mid-flush -> flush stays 1, counter frozen, resumes after stall falls.
6. Simultaneous is_ret, is_b and is_cmp with op1=0x80 -> ret wins (pc=0x80) and flags update. Assert reset mid-flush -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC execute-stage types: datapath widths, flush FSM states, branch kinds.
package simplerisc_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned OFF_W  = 27;
    localparam logic [3:0]  RA_IDX = 4'd15;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_B    = 3'd1,
        BR_BEQ  = 3'd2,
        BR_BGT  = 3'd3,
        BR_CALL = 3'd4,
        BR_RET  = 3'd5
    } br_kind_e;

    // Collapse possibly-overlapping decode bits: ret > call > b > bgt > beq.
    function automatic br_kind_e decode_branch(
        input logic is_b,
        input logic is_beq,
        input logic is_bgt,
        input logic is_call,
        input logic is_ret
    );
        br_kind_e kind;
        kind = BR_NONE;
        if (is_ret)       kind = BR_RET;
        else if (is_call) kind = BR_CALL;
        else if (is_b)    kind = BR_B;
        else if (is_bgt)  kind = BR_BGT;
        else if (is_beq)  kind = BR_BEQ;
        return kind;
    endfunction

endpackage

// File: rtl/branch_flags_unit_if.sv
// Execute-stage bundle between the pipeline (master) and branch_flags_unit (slave).
interface branch_flags_unit_if;
    import simplerisc_pkg::*;

    logic             stall;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             is_cmp;
    logic             gt_in;
    logic             eq_in;
    logic             is_b;
    logic             is_beq;
    logic             is_bgt;
    logic             is_call;
    logic             is_ret;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  op1;

    logic [PC_W-1:0]  pc;
    logic             flag_gt;
    logic             flag_eq;
    logic             branch_taken;
    logic [PC_W-1:0]  branch_pc;
    logic             ra_wr_en;
    logic [PC_W-1:0]  ra_wr_data;
    logic             flush;

    modport master (
        output stall, ex_valid, ex_pc, is_cmp, gt_in, eq_in,
               is_b, is_beq, is_bgt, is_call, is_ret, offset, op1,
        input  pc, flag_gt, flag_eq, branch_taken, branch_pc,
               ra_wr_en, ra_wr_data, flush
    );

    modport slave (
        input  stall, ex_valid, ex_pc, is_cmp, gt_in, eq_in,
               is_b, is_beq, is_bgt, is_call, is_ret, offset, op1,
        output pc, flag_gt, flag_eq, branch_taken, branch_pc,
               ra_wr_en, ra_wr_data, flush
    );

endinterface

// File: rtl/branch_target_calc.sv
// Redirect target: op1 for ret, otherwise ex_pc plus the sign-extended word offset.
module branch_target_calc
    import simplerisc_pkg::*;
(
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  op1,
    input  logic             is_ret,
    output logic [PC_W-1:0]  target_c
);

    logic [PC_W-1:0] off_ext_c;
    logic [PC_W-1:0] rel_target_c;

    always_comb begin
        off_ext_c    = PC_W'($signed(offset));
        rel_target_c = ex_pc + (off_ext_c << 2);
        target_c     = is_ret ? op1 : rel_target_c;
    end

endmodule

// File: rtl/branch_flags_unit.sv
// Flags register, branch resolution, fetch PC and counted post-redirect flush.
module branch_flags_unit
    import simplerisc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
)
(
    input logic               clk,
    input logic               reset,
    branch_flags_unit_if.slave bus
);

    localparam int unsigned     CNT_W      = 3;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    flush_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  branch_pc_q, branch_pc_d;
    logic [PC_W-1:0]  ra_wr_data_q, ra_wr_data_d;
    logic             flag_gt_q, flag_gt_d;
    logic             flag_eq_q, flag_eq_d;
    logic             branch_taken_q, branch_taken_d;
    logic             ra_wr_en_q, ra_wr_en_d;
    logic             flush_q, flush_d;

    logic             eff_c;
    logic             taken_c;
    logic             is_ret_c;
    br_kind_e         kind_c;
    logic [PC_W-1:0]  target_c;

    // Branches see only the registered flags; a same-cycle cmp is not forwarded.
    always_comb begin
        eff_c    = bus.ex_valid & ~bus.stall & (state_q == RUN);
        kind_c   = decode_branch(bus.is_b, bus.is_beq, bus.is_bgt, bus.is_call, bus.is_ret);
        is_ret_c = (kind_c == BR_RET);
        taken_c  = 1'b0;
        case (kind_c)
            BR_B, BR_CALL, BR_RET: taken_c = eff_c;
            BR_BEQ:                taken_c = eff_c & flag_eq_q;
            BR_BGT:                taken_c = eff_c & flag_gt_q;
            default:               taken_c = 1'b0;
        endcase
    end

    branch_target_calc u_target (
        .ex_pc    (bus.ex_pc),
        .offset   (bus.offset),
        .op1      (bus.op1),
        .is_ret   (is_ret_c),
        .target_c (target_c)
    );

    // Next state; stall freezes everything except the one-shot pulses, which drop.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_d           = pc_q;
        branch_pc_d    = branch_pc_q;
        ra_wr_data_d   = ra_wr_data_q;
        flag_gt_d      = flag_gt_q;
        flag_eq_d      = flag_eq_q;
        flush_d        = flush_q;
        branch_taken_d = 1'b0;
        ra_wr_en_d     = 1'b0;

        if (!bus.stall) begin
            if (eff_c && bus.is_cmp) begin
                flag_gt_d = bus.gt_in;
                flag_eq_d = bus.eq_in;
            end

            if (taken_c) begin
                pc_d           = target_c;
                branch_taken_d = 1'b1;
                branch_pc_d    = target_c;
                state_d        = FLUSH;
                cnt_d          = FLUSH_LOAD;
                if (kind_c == BR_CALL) begin
                    ra_wr_en_d   = 1'b1;
                    ra_wr_data_d = bus.ex_pc + PC_W'(4);
                end
            end else begin
                pc_d = pc_q + PC_W'(4);
                if ((state_q == FLUSH) && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            flush_d = (cnt_d != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            pc_q           <= RESET_PC;
            branch_pc_q    <= '0;
            ra_wr_data_q   <= '0;
            flag_gt_q      <= 1'b0;
            flag_eq_q      <= 1'b0;
            branch_taken_q <= 1'b0;
            ra_wr_en_q     <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pc_q           <= pc_d;
            branch_pc_q    <= branch_pc_d;
            ra_wr_data_q   <= ra_wr_data_d;
            flag_gt_q      <= flag_gt_d;
            flag_eq_q      <= flag_eq_d;
            branch_taken_q <= branch_taken_d;
            ra_wr_en_q     <= ra_wr_en_d;
            flush_q        <= flush_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.flag_gt      = flag_gt_q;
    assign bus.flag_eq      = flag_eq_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.branch_pc    = branch_pc_q;
    assign bus.ra_wr_en     = ra_wr_en_q;
    assign bus.ra_wr_data   = ra_wr_data_q;
    assign bus.flush        = flush_q;

endmodule

// File: tb/tb_branch_flags_unit.sv
// Scoreboard bench for branch_flags_unit: a behavioural model queues the expected
// post-edge outputs for every driven cycle; directed checks pin the key scenarios.
module tb_branch_flags_unit;
    import simplerisc_pkg::*;

    localparam int unsigned FLUSH_N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_flags_unit_if bus ();

    branch_flags_unit #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (FLUSH_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        gt;
        logic        eq;
        logic        bt;
        logic [31:0] bpc;
        logic        rawe;
        logic [31:0] rad;
        logic        fl;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] m_pc, m_bpc, m_rad;
    logic        m_gt, m_eq, m_bt, m_rawe;
    int          m_left;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_bpc = 32'h0; m_rad = 32'h0;
        m_gt = 1'b0; m_eq = 1'b0; m_bt = 1'b0; m_rawe = 1'b0;
        m_left = 0;
        sb.delete();
    endtask

    // Predict outputs after the coming edge from current inputs and model state.
    task automatic model_step();
        exp_t        e;
        logic [31:0] tgt;
        logic        taken;
        int          o;
        taken = 1'b0;
        tgt   = 32'h0;
        if (bus.stall) begin
            m_bt   = 1'b0;
            m_rawe = 1'b0;
        end else begin
            m_rawe = 1'b0;
            if (bus.ex_valid && m_left == 0) begin
                o   = int'($signed(bus.offset));
                tgt = bus.is_ret ? bus.op1 : bus.ex_pc + 32'(o * 4);
                if (bus.is_ret || bus.is_call || bus.is_b) taken = 1'b1;
                else if (bus.is_bgt)                       taken = m_gt;
                else if (bus.is_beq)                       taken = m_eq;
                if (taken && bus.is_call && !bus.is_ret) begin
                    m_rawe = 1'b1;
                    m_rad  = bus.ex_pc + 32'd4;
                end
                if (bus.is_cmp) begin
                    m_gt = bus.gt_in;
                    m_eq = bus.eq_in;
                end
            end
            if (taken) begin
                m_pc   = tgt;
                m_bpc  = tgt;
                m_bt   = 1'b1;
                m_left = FLUSH_N;
            end else begin
                m_pc = m_pc + 32'd4;
                m_bt = 1'b0;
                if (m_left > 0) m_left--;
            end
        end
        e = '{pc: m_pc, gt: m_gt, eq: m_eq, bt: m_bt, bpc: m_bpc,
              rawe: m_rawe, rad: m_rad, fl: (m_left > 0)};
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got no expectation expected one queued");
        end else begin
            e = sb.pop_front();
            check_eq("sb_pc",         bus.pc,                  e.pc);
            check_eq("sb_flag_gt",    32'(bus.flag_gt),        32'(e.gt));
            check_eq("sb_flag_eq",    32'(bus.flag_eq),        32'(e.eq));
            check_eq("sb_branch_tkn", 32'(bus.branch_taken),   32'(e.bt));
            check_eq("sb_branch_pc",  bus.branch_pc,           e.bpc);
            check_eq("sb_ra_wr_en",   32'(bus.ra_wr_en),       32'(e.rawe));
            check_eq("sb_ra_wr_data", bus.ra_wr_data,          e.rad);
            check_eq("sb_flush",      32'(bus.flush),          32'(e.fl));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle();
        bus.stall    = 1'b0;
        bus.ex_valid = 1'b0;
        bus.ex_pc    = 32'h0;
        bus.is_cmp   = 1'b0;
        bus.gt_in    = 1'b0;
        bus.eq_in    = 1'b0;
        bus.is_b     = 1'b0;
        bus.is_beq   = 1'b0;
        bus.is_bgt   = 1'b0;
        bus.is_call  = 1'b0;
        bus.is_ret   = 1'b0;
        bus.offset   = 27'h0;
        bus.op1      = 32'h0;
    endtask

    task automatic do_cmp(input logic gt, input logic eq);
        idle();
        bus.ex_valid = 1'b1;
        bus.is_cmp   = 1'b1;
        bus.gt_in    = gt;
        bus.eq_in    = eq;
        step();
    endtask

    task automatic do_br(input br_kind_e k, input logic [31:0] pc, input logic [26:0] off,
                         input logic [31:0] op);
        idle();
        bus.ex_valid = 1'b1;
        bus.ex_pc    = pc;
        bus.offset   = off;
        bus.op1      = op;
        case (k)
            BR_B:    bus.is_b    = 1'b1;
            BR_BEQ:  bus.is_beq  = 1'b1;
            BR_BGT:  bus.is_bgt  = 1'b1;
            BR_CALL: bus.is_call = 1'b1;
            BR_RET:  bus.is_ret  = 1'b1;
            default: ;
        endcase
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        #3;
        check_eq("rst_pc",    bus.pc,           32'h0);
        check_eq("rst_gt",    32'(bus.flag_gt), 32'h0);
        check_eq("rst_flush", 32'(bus.flush),   32'h0);
        #7;
        reset = 1'b1;

        // Free-running fetch
        repeat (3) step();
        check_eq("pc_after3", bus.pc, 32'd12);

        // Taken bgt after cmp 30 vs 10
        do_cmp(1'b1, 1'b0);
        do_br(BR_BGT, 32'h40, 27'd3, 32'h0);
        check_eq("bgt_taken", 32'(bus.branch_taken), 32'h1);
        check_eq("bgt_bpc",   bus.branch_pc,         32'h4C);
        check_eq("bgt_pc",    bus.pc,                32'h4C);
        check_eq("bgt_fl1",   32'(bus.flush),        32'h1);
        idle();
        step();
        check_eq("bgt_pulse", 32'(bus.branch_taken), 32'h0);
        check_eq("bgt_fl2",   32'(bus.flush),        32'h1);
        step();
        check_eq("bgt_fl3",   32'(bus.flush),        32'h0);

        // Taken beq with negative offset, then not-taken bgt
        do_cmp(1'b0, 1'b1);
        do_br(BR_BEQ, 32'h100, 27'h7FF_FFFE, 32'h0);
        check_eq("beq_bpc", bus.branch_pc, 32'hF8);
        idle();
        repeat (2) step();
        do_cmp(1'b0, 1'b0);
        do_br(BR_BGT, 32'h180, 27'd4, 32'h0);
        check_eq("bgt_nt_tkn",   32'(bus.branch_taken), 32'h0);
        check_eq("bgt_nt_flush", 32'(bus.flush),        32'h0);

        // call, stall on the pulse cycle, then ret
        do_br(BR_CALL, 32'h200, 27'h10, 32'h0);
        check_eq("call_ra_en", 32'(bus.ra_wr_en), 32'h1);
        check_eq("call_ra",    bus.ra_wr_data,    32'h204);
        check_eq("call_pc",    bus.pc,            32'h240);
        idle();
        bus.stall = 1'b1;
        step();
        check_eq("stall_ra_en", 32'(bus.ra_wr_en), 32'h0);
        check_eq("stall_pc",    bus.pc,            32'h240);
        bus.stall = 1'b0;
        repeat (2) step();
        check_eq("call_fl_end", 32'(bus.flush), 32'h0);
        do_br(BR_RET, 32'h260, 27'h0, 32'h204);
        check_eq("ret_pc", bus.pc, 32'h204);
        idle();
        repeat (2) step();

        // Wrapping target, then wrong-path cmp/b and a stall inside the flush
        do_br(BR_B, 32'hFFFF_FFF0, 27'd8, 32'h0);
        check_eq("wrap_pc", bus.pc, 32'h10);
        idle();
        bus.ex_valid = 1'b1;
        bus.is_cmp   = 1'b1;
        bus.gt_in    = 1'b1;
        bus.eq_in    = 1'b1;
        bus.is_b     = 1'b1;
        bus.ex_pc    = 32'h500;
        bus.offset   = 27'd1;
        step();
        check_eq("wp_taken", 32'(bus.branch_taken), 32'h0);
        check_eq("wp_gt",    32'(bus.flag_gt),      32'h0);
        check_eq("wp_eq",    32'(bus.flag_eq),      32'h0);
        idle();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_flush", 32'(bus.flush), 32'h1);
        end
        bus.stall = 1'b0;
        step();
        check_eq("stall_resume", 32'(bus.flush), 32'h0);

        // ret beats b; cmp still writes the flags
        idle();
        bus.ex_valid = 1'b1;
        bus.is_ret   = 1'b1;
        bus.is_b     = 1'b1;
        bus.is_cmp   = 1'b1;
        bus.gt_in    = 1'b1;
        bus.eq_in    = 1'b0;
        bus.op1      = 32'h80;
        bus.ex_pc    = 32'h600;
        bus.offset   = 27'd5;
        step();
        check_eq("prio_pc", bus.pc,           32'h80);
        check_eq("prio_gt", 32'(bus.flag_gt), 32'h1);
        check_eq("prio_fl", 32'(bus.flush),   32'h1);

        // Asynchronous reset in the middle of the flush
        idle();
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_pc",    bus.pc,                32'h0);
        check_eq("arst_gt",    32'(bus.flag_gt),      32'h0);
        check_eq("arst_eq",    32'(bus.flag_eq),      32'h0);
        check_eq("arst_bt",    32'(bus.branch_taken), 32'h0);
        check_eq("arst_bpc",   bus.branch_pc,         32'h0);
        check_eq("arst_raen",  32'(bus.ra_wr_en),     32'h0);
        check_eq("arst_ra",    bus.ra_wr_data,        32'h0);
        check_eq("arst_flush", 32'(bus.flush),        32'h0);
        model_reset();
        #3;
        reset = 1'b1;
        repeat (2) step();
        check_eq("post_rst_pc", bus.pc, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
